qubit_measure_unit: RTL and testbench

Projective measurement stage downstream of the two-qubit Bell-state circuit. It accepts one snapshot of the eight Q8.8 amplitudes (c00..c11, re/im) and computes the four basis-state probabilities |c|². It then draws one pseudo-random measurement outcome weighted by those probabilities and returns it over a valid/ready handshake. Repeated shots against the same state give the outcome statistics that software compares with theory.

---
 rtl/qubit_measure_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_qubit_measure_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qubit_measure_unit.sv
// qubit_measure_unit
// Projective measurement of a two-qubit state. One snapshot of four complex Q8.8
// amplitudes is squared into four basis-state probabilities, one per cycle on a
// shared multiplier pair. An outcome is then drawn from a free-running Galois LFSR,
// weighted by those probabilities, and held on a valid/ready output until consumed.
//
// Optional feature: define MEASURE_HISTOGRAM_EN to build four saturating outcome
// counters (hist_*). Without it, hist_* are constant zero.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   in_valid / in_ready     amplitude snapshot handshake (ready only in idle)
//   cXY_re, cXY_im          signed Q8.8 amplitudes of basis state |XY>
//   meas_valid / meas_ready result handshake
//   meas_outcome            measured basis state {q1,q0}
//   meas_err                every probability was zero; outcome forced to 2'b00
//   prob_XY                 unsigned Q8.8 probabilities of the current result
//   hist_XY                 outcome counters (zero when the histogram is not built)

module qubit_measure_unit #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned HIST_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       c00_re,
  input  logic [15:0]       c00_im,
  input  logic [15:0]       c01_re,
  input  logic [15:0]       c01_im,
  input  logic [15:0]       c10_re,
  input  logic [15:0]       c10_im,
  input  logic [15:0]       c11_re,
  input  logic [15:0]       c11_im,
  output logic              meas_valid,
  input  logic              meas_ready,
  output logic [1:0]        meas_outcome,
  output logic              meas_err,
  output logic [15:0]       prob_00,
  output logic [15:0]       prob_01,
  output logic [15:0]       prob_10,
  output logic [15:0]       prob_11,
  output logic [HIST_W-1:0] hist_00,
  output logic [HIST_W-1:0] hist_01,
  output logic [HIST_W-1:0] hist_10,
  output logic [HIST_W-1:0] hist_11
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [15:0] SeedEff  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LfsrMask = 16'hB400;

  typedef enum logic [1:0] {StIdle, StSquare, StDraw, StHold} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic [15:0] amp_re_q [4];
  logic [15:0] amp_im_q [4];
  logic [15:0] p_q      [4];
  logic [15:0] prob_q   [4];
  logic [1:0]  outcome_q;
  logic        err_q;

  logic        accept;
  logic        handshake;

  assign accept    = (state_q == StIdle) && in_valid;
  assign handshake = (state_q == StHold) && meas_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StSquare;
          k_d     = 2'd0;
        end
      end
      StSquare: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = StDraw;
      end
      StDraw: state_d = StHold;
      StHold: begin
        if (meas_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready is masked during reset so that it reads low while reset is held.
  assign in_ready   = (state_q == StIdle) && !reset;
  assign meas_valid = (state_q == StHold);

  // ---------------------------------------------------------------------------
  // Free-running Galois LFSR (x^16+x^14+x^13+x^11+1)
  // ---------------------------------------------------------------------------
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LfsrMask;
  end

  // ---------------------------------------------------------------------------
  // Squaring datapath: one basis state per cycle on a shared multiplier pair
  // ---------------------------------------------------------------------------
  logic signed [31:0] sq_re, sq_im;
  logic        [31:0] re_sq, im_sq;
  logic        [32:0] sum_sq;
  logic        [24:0] sum_shr;
  logic        [15:0] p_new;

  always_comb begin
    sq_re   = 32'($signed(amp_re_q[k_q]));
    sq_im   = 32'($signed(amp_im_q[k_q]));
    re_sq   = 32'(sq_re * sq_re);
    im_sq   = 32'(sq_im * sq_im);
    // Each square is at most 2^30, so the 33-bit sum cannot overflow.
    sum_sq  = {1'b0, re_sq} + {1'b0, im_sq};
    sum_shr = 25'(sum_sq >> 8);
    p_new   = (|sum_shr[24:16]) ? 16'hFFFF : sum_shr[15:0];
  end

  // ---------------------------------------------------------------------------
  // Weighted draw
  // ---------------------------------------------------------------------------
  logic [17:0] cum0, cum1, cum2, cum3;
  logic [25:0] r_prod;
  logic [17:0] r_scaled;
  logic [1:0]  draw_outcome;
  logic        draw_err;

  always_comb begin
    cum0     = 18'(p_q[0]);
    cum1     = cum0 + 18'(p_q[1]);
    cum2     = cum1 + 18'(p_q[2]);
    cum3     = cum2 + 18'(p_q[3]);
    // r8/256 of the total, so r_scaled < cum3 whenever the total is non-zero.
    r_prod   = 26'(lfsr_q[7:0]) * 26'(cum3);
    r_scaled = 18'(r_prod >> 8);
    draw_err = 1'b0;
    // A zero-probability state has cum_k == cum_(k-1) and can never win here.
    if (cum3 == 18'd0) begin
      draw_outcome = 2'b00;
      draw_err     = 1'b1;
    end else if (r_scaled < cum0) begin
      draw_outcome = 2'b00;
    end else if (r_scaled < cum1) begin
      draw_outcome = 2'b01;
    end else if (r_scaled < cum2) begin
      draw_outcome = 2'b10;
    end else begin
      draw_outcome = 2'b11;
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      k_q       <= 2'd0;
      lfsr_q    <= SeedEff;
      outcome_q <= 2'b00;
      err_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        amp_re_q[i] <= 16'h0000;
        amp_im_q[i] <= 16'h0000;
        p_q[i]      <= 16'h0000;
        prob_q[i]   <= 16'h0000;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      if (accept) begin
        amp_re_q[0] <= c00_re;
        amp_im_q[0] <= c00_im;
        amp_re_q[1] <= c01_re;
        amp_im_q[1] <= c01_im;
        amp_re_q[2] <= c10_re;
        amp_im_q[2] <= c10_im;
        amp_re_q[3] <= c11_re;
        amp_im_q[3] <= c11_im;
      end
      if (state_q == StSquare) begin
        p_q[k_q] <= p_new;
      end
      // Outputs change only here, so they stay frozen for the whole of HOLD.
      if (state_q == StDraw) begin
        outcome_q <= draw_outcome;
        err_q     <= draw_err;
        for (int i = 0; i < 4; i++) prob_q[i] <= p_q[i];
      end
    end
  end

  assign meas_outcome = outcome_q;
  assign meas_err     = err_q;
  assign prob_00      = prob_q[0];
  assign prob_01      = prob_q[1];
  assign prob_10      = prob_q[2];
  assign prob_11      = prob_q[3];

  // ---------------------------------------------------------------------------
  // Optional outcome histogram
  // ---------------------------------------------------------------------------
`ifdef MEASURE_HISTOGRAM_EN
  localparam logic [HIST_W-1:0] HistOne = {{(HIST_W-1){1'b0}}, 1'b1};

  logic [HIST_W-1:0] hist_q [4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
    end else if (handshake && !err_q && (hist_q[outcome_q] != {HIST_W{1'b1}})) begin
      hist_q[outcome_q] <= hist_q[outcome_q] + HistOne;
    end
  end

  assign hist_00 = hist_q[0];
  assign hist_01 = hist_q[1];
  assign hist_10 = hist_q[2];
  assign hist_11 = hist_q[3];
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
  assign hist_00 = '0;
  assign hist_01 = '0;
  assign hist_10 = '0;
  assign hist_11 = '0;
`endif

endmodule

// File: tb/tb_qubit_measure_unit.sv
// Self-checking bench for qubit_measure_unit. A shot-level model runs alongside the
// DUT and is compared against every output on every falling clock edge; directed
// literal checks pin the model for the Bell, |00>, zero and histogram cases.
`timescale 1ns/1ps

module tb_qubit_measure_unit;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int unsigned HW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   c00_re, c00_im, c01_re, c01_im, c10_re, c10_im, c11_re, c11_im;
  logic          meas_valid;
  logic          meas_ready;
  logic [1:0]    meas_outcome;
  logic          meas_err;
  logic [15:0]   prob_00, prob_01, prob_10, prob_11;
  logic [HW-1:0] hist_00, hist_01, hist_10, hist_11;

  always #5 clk = ~clk;

  qubit_measure_unit #(
    .LFSR_SEED (SEED),
    .HIST_W    (HW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .c00_re       (c00_re),
    .c00_im       (c00_im),
    .c01_re       (c01_re),
    .c01_im       (c01_im),
    .c10_re       (c10_re),
    .c10_im       (c10_im),
    .c11_re       (c11_re),
    .c11_im       (c11_im),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .meas_outcome (meas_outcome),
    .meas_err     (meas_err),
    .prob_00      (prob_00),
    .prob_01      (prob_01),
    .prob_10      (prob_10),
    .prob_11      (prob_11),
    .hist_00      (hist_00),
    .hist_01      (hist_01),
    .hist_10      (hist_10),
    .hist_11      (hist_11)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] prob_of(input logic [15:0] re, input logic [15:0] im);
    longint r = longint'($signed(re));
    longint i = longint'($signed(im));
    longint s = (r * r + i * i) / 256;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  bit          m_idle = 1'b1;
  bit          m_hold = 1'b0;
  int          m_cnt  = 0;
  logic [15:0] m_lfsr = SEED;
  logic [15:0] m_p    [4];
  logic [15:0] m_prob [4];
  logic [1:0]  m_out  = 2'b00;
  logic        m_err  = 1'b0;
  int unsigned m_hist [4];

  task automatic model_draw(input logic [7:0] r8);
    longint total = 0;
    longint acc   = 0;
    longint rs;
    for (int k = 0; k < 4; k++) total += longint'(m_p[k]);
    rs    = (longint'(r8) * total) / 256;
    m_err = (total == 0);
    m_out = 2'b00;
    if (total != 0) begin
      for (int k = 3; k >= 0; k--) begin
        acc = 0;
        for (int j = 0; j <= k; j++) acc += longint'(m_p[j]);
        if (rs < acc) m_out = 2'(k);
      end
    end
    for (int k = 0; k < 4; k++) m_prob[k] = m_p[k];
  endtask

  function automatic logic [HW-1:0] exp_hist(input int idx);
`ifdef MEASURE_HISTOGRAM_EN
    return HW'(m_hist[idx]);
`else
    return (idx < 0) ? {HW{1'b1}} : '0;
`endif
  endfunction

  // Compare-and-advance: check the current cycle, then apply the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_meas_valid", meas_valid, 0);
      chk("rst_outcome", {meas_err, meas_outcome}, 0);
      chk("rst_probs", {prob_00, prob_01, prob_10, prob_11}, 0);
      chk("rst_hist", {hist_00, hist_01, hist_10, hist_11}, 0);
      m_idle = 1'b1;
      m_hold = 1'b0;
      m_cnt  = 0;
      m_lfsr = SEED;
      m_out  = 2'b00;
      m_err  = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_p[k] = '0; m_prob[k] = '0; m_hist[k] = 0;
      end
    end else begin
      chk("in_ready", in_ready, m_idle);
      chk("meas_valid", meas_valid, m_hold);
      chk("meas_outcome", meas_outcome, m_out);
      chk("meas_err", meas_err, m_err);
      chk("prob_00", prob_00, m_prob[0]);
      chk("prob_01", prob_01, m_prob[1]);
      chk("prob_10", prob_10, m_prob[2]);
      chk("prob_11", prob_11, m_prob[3]);
      chk("hist_00", hist_00, exp_hist(0));
      chk("hist_01", hist_01, exp_hist(1));
      chk("hist_10", hist_10, exp_hist(2));
      chk("hist_11", hist_11, exp_hist(3));
      if (m_idle) begin
        if (in_valid) begin
          m_p[0] = prob_of(c00_re, c00_im);
          m_p[1] = prob_of(c01_re, c01_im);
          m_p[2] = prob_of(c10_re, c10_im);
          m_p[3] = prob_of(c11_re, c11_im);
          m_idle = 1'b0;
          m_cnt  = 0;
        end
      end else if (m_hold) begin
        if (meas_ready) begin
          if (!m_err && m_hist[m_out] < (2 ** HW) - 1) m_hist[m_out]++;
          m_hold = 1'b0;
          m_idle = 1'b1;
        end
      end else if (m_cnt == 4) begin
        model_draw(m_lfsr[7:0]);
        m_hold = 1'b1;
      end else begin
        m_cnt++;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [1:0] s_out;
  logic       s_err;
  int         s_edges;

  task automatic scramble();
    {c00_re, c00_im, c01_re, c01_im} = {$urandom, $urandom};
    {c10_re, c10_im, c11_re, c11_im} = {$urandom, $urandom};
  endtask

  task automatic set_amps(input logic [7:0][15:0] a);
    {c00_re, c00_im, c01_re, c01_im, c10_re, c10_im, c11_re, c11_im} = a;
  endtask

  // One shot: present amplitudes, wait for the result, hold off meas_ready for
  // `hold` cycles (optionally poking in_valid mid-hold), then hand it off.
  task automatic shot(input logic [7:0][15:0] a, input int hold, input bit poke);
    int n;
    bit ok;
    @(posedge clk); #2;
    set_amps(a);
    in_valid   = 1'b1;
    meas_ready = (hold == 0);
    ok = 1'b0;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("timeout_in_ready", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    scramble();
    ok = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (meas_valid) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("timeout_meas_valid", 0, 1);
      return;
    end
    s_edges = n - 1;
    s_out   = meas_outcome;
    s_err   = meas_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      in_valid = poke && (i == hold / 2);
      if (in_valid) set_amps(a);
    end
    if (hold > 0) begin
      @(posedge clk); #2;
      in_valid   = 1'b0;
      meas_ready = 1'b1;
    end
    @(posedge clk); #2;
    meas_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  logic [7:0][15:0] bell, ket00, zero, rnd;
  int n00, n11, nother, nerr;

  initial begin
    bell  = {16'h00B5, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00B5, 16'h0};
    ket00 = {16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    zero  = '0;
    reset = 1'b1;
    in_valid = 1'b0;
    meas_ready = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_first_cycle", in_ready, 1);

    // |00> shots: fixed probability, outcome and latency; histogram saturates.
    for (int s = 0; s < 50; s++) begin
      shot(ket00, 0, 1'b0);
      chk("ket00_prob00", prob_00, 16'h0100);
      chk("ket00_outcome", s_out, 2'b00);
      chk("ket00_latency", s_edges, 5);
      if (s == 19) begin
`ifdef MEASURE_HISTOGRAM_EN
        chk("hist00_saturated", hist_00, 15);
`else
        chk("hist00_absent", hist_00, 0);
`endif
        chk("hist_others_zero", {hist_01, hist_10, hist_11}, 0);
      end
    end

    // Bell state statistics.
    n00 = 0; n11 = 0; nother = 0; nerr = 0;
    for (int s = 0; s < 1000; s++) begin
      shot(bell, 0, 1'b0);
      chk("bell_probs", {prob_00, prob_01, prob_10, prob_11},
          {16'h007F, 16'h0, 16'h0, 16'h007F});
      if (s_err) nerr++;
      if (s_out == 2'b00) n00++;
      else if (s_out == 2'b11) n11++;
      else nother++;
    end
    chk("bell_n00_in_range", (n00 >= 400 && n00 <= 600), 1);
    chk("bell_n11_in_range", (n11 >= 400 && n11 <= 600), 1);
    chk("bell_no_mixed", nother, 0);
    chk("bell_no_err", nerr, 0);

    // All-zero amplitudes.
    shot(zero, 0, 1'b0);
    chk("zero_err", s_err, 1);
    chk("zero_outcome", s_out, 2'b00);
    chk("zero_probs", {prob_00, prob_01, prob_10, prob_11}, 0);

    // Backpressure with an ignored in_valid pulse.
    shot(bell, 10, 1'b1);

    // Reset during the k = 2 squaring cycle.
    @(posedge clk); #2;
    set_amps(ket00);
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_meas_valid", meas_valid, 0);
    repeat (8) @(negedge clk);
    chk("abort_no_result", meas_valid, 0);
    shot(ket00, 0, 1'b0);
    chk("post_abort_outcome", s_out, 2'b00);
    chk("post_abort_latency", s_edges, 5);

    // Randomised shots with random backpressure.
    for (int s = 0; s < 200; s++) begin
      for (int j = 0; j < 8; j++) begin
        case ($urandom_range(0, 3))
          0: rnd[j] = 16'($urandom);
          1: rnd[j] = 16'h0;
          default: rnd[j] = 16'(int'($urandom_range(0, 512)) - 256);
        endcase
      end
      shot(rnd, $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
